// File: rtl/cpu_if_pkg.sv
// Shared definitions for the CPU interface master: FSM state encoding and
// default parameter values.
package cpu_if_pkg;

    localparam int unsigned AW_DEF      = 16;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_if_timer.sv
// Saturating wait counter for the BUSY phase; expired flags the last cycle
// the master may wait for an acknowledge.
module cpu_if_timer
    import cpu_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_l,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/cpu_if_master.sv
// Single-outstanding command-to-bus master with acknowledge timeout; one
// command is accepted, issued on the bus, and answered with one result strobe.
module cpu_if_master
    import cpu_if_pkg::*;
#(
    parameter int unsigned AW          = AW_DEF,
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          cpu_req,
    output logic          cpu_we,
    output logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_wdata,
    input  logic          cpu_ack,
    input  logic [DW-1:0] cpu_rdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          cpu_if_timeout
);

    state_e        state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          cpu_we_q, cpu_we_d;
    logic [AW-1:0] cpu_addr_q, cpu_addr_d;
    logic [DW-1:0] cpu_wdata_q, cpu_wdata_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          timeout_q, timeout_d;
    logic          expired;

    // Counter is held at zero outside BUSY, so it starts from zero on every entry.
    cpu_if_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset_l(reset_l),
        .clear  (state_q != ST_BUSY),
        .enable ((state_q == ST_BUSY) && !cpu_ack),
        .expired(expired)
    );

    always_comb begin
        state_d     = state_q;
        cpu_we_d    = cpu_we_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ST_BUSY;
                    cpu_we_d    = cmd_write;
                    cpu_addr_d  = cmd_addr;
                    cpu_wdata_d = cmd_wdata;
                end
            end
            ST_BUSY: begin
                // Acknowledge takes priority over a simultaneous timeout.
                if (cpu_ack) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = cpu_we_q ? '0 : cpu_rdata;
                    rsp_err_d   = 1'b0;
                end else if (expired) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cpu_we_q    <= cpu_we_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_wdata_q <= cpu_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign cpu_req        = (state_q == ST_BUSY);
    assign cpu_we         = cpu_we_q;
    assign cpu_addr       = cpu_addr_q;
    assign cpu_wdata      = cpu_wdata_q;
    assign rsp_valid      = (state_q == ST_RESP);
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign cpu_if_timeout = timeout_q;

endmodule

// File: doc/cpu_if_master.md
CPU_IF_MASTER -- requirements
Module: cpu_if_master

Interface
REQ-001 Parameters SHALL be: AW, default 16, address width; DW, default 32, data width; TIMEOUT_CYC, default 255, maximum cycles to wait for ack (legal range 1..65535).
REQ-002 Ports SHALL be: clk  input  1  single clock, all logic on posedge clk.
REQ-003 reset_l  input  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both are high.
REQ-005 cmd_write  input  1  1=write, 0=read; cmd_addr  input  AW; cmd_wdata  input  DW.
REQ-006 cpu_req  output  1  bus request to responder; cpu_we  output  1; cpu_addr  output  AW; cpu_wdata  output  DW.
REQ-007 cpu_ack  input  1  responder completion; cpu_rdata  input  DW  read data, valid with cpu_ack.
REQ-008 rsp_valid  output  1  one-cycle result strobe; rsp_rdata  output  DW; rsp_err  output  1  transaction timed out.
REQ-009 cpu_if_timeout  output  1  one-cycle timeout pulse toward the responder's timeout input.

Function
REQ-010 FSM states SHALL be IDLE, BUSY, RESP; reset state IDLE.
REQ-011 cmd_ready SHALL be high only in IDLE, as a registered output.
REQ-012 IDLE->BUSY on cmd_valid&&cmd_ready; cmd_write/addr/wdata captured into cpu_we/cpu_addr/cpu_wdata that edge.
REQ-013 cpu_req SHALL be high exactly in BUSY; first cpu_req cycle is the cycle after acceptance.
REQ-014 cpu_we/cpu_addr/cpu_wdata SHALL hold stable for the whole BUSY period.
REQ-015 Wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without cpu_ack; width $clog2(TIMEOUT_CYC+1), saturating, never wraps.
REQ-016 cpu_ack in BUSY: go to RESP; capture cpu_rdata for reads, zero for writes; rsp_err=0.
REQ-017 Counter equal to TIMEOUT_CYC-1 with no cpu_ack: go to RESP, rsp_rdata=0, rsp_err=1, cpu_if_timeout high for exactly the RESP cycle.
REQ-018 cpu_ack in the same cycle the timeout threshold is reached: ack SHALL win; no timeout.
REQ-019 Thus a transaction with no ack SHALL hold cpu_req for exactly TIMEOUT_CYC cycles.
REQ-020 RESP SHALL last one cycle with rsp_valid=1, then IDLE; rsp_rdata/rsp_err hold until the next RESP.
REQ-021 cpu_ack outside BUSY SHALL be ignored, no state or output change.
REQ-022 Back-to-back: minimum period is 3 cycles per command (accept, BUSY>=1, RESP).

Reset
REQ-023 On reset_l low, immediately and asynchronously: state IDLE, cmd_ready=0, cpu_req=0, cpu_we=0, cpu_addr=0, cpu_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cpu_if_timeout=0, counter=0.
REQ-024 cmd_ready SHALL rise on the first clk edge after reset_l deasserts.
REQ-025 Reset mid-transaction SHALL abandon it with no rsp_valid and no cpu_if_timeout pulse.

Structure
REQ-026 Package cpu_if_pkg SHALL hold the state enum and default AW/DW/TIMEOUT_CYC constants.
REQ-027 Wait counter SHALL be sub-module cpu_if_timer (inputs clear, enable; output expired); FSM and datapath stay in cpu_if_master.

Verification
REQ-028 Read, addr 0x0010, ack after 3 BUSY cycles with rdata 0xDEADBEEF -> rsp_valid one cycle, rsp_rdata=0xDEADBEEF, rsp_err=0, cpu_if_timeout never high.
REQ-029 Write, addr 0x0004, wdata 0x12345678, no ack, TIMEOUT_CYC=8 -> cpu_req high 8 cycles, then rsp_err=1, rsp_rdata=0, cpu_if_timeout one-cycle pulse.
REQ-030 TIMEOUT_CYC=8, ack on 8th BUSY cycle -> rsp_err=0, no cpu_if_timeout pulse.
REQ-031 Spurious cpu_ack in IDLE, then read with ack after 1 cycle -> only one rsp_valid, data from real ack.
REQ-032 reset_l low on 4th BUSY cycle -> all outputs 0 asynchronously, no rsp_valid; cmd_ready=1 one edge after release.
REQ-033 cmd_valid held high for 4 commands, ack immediate -> 4 rsp_valid strobes, 3-cycle spacing, fields match each command.
